// File: rtl/l1_refill_pkg.sv
// Shared types for the L1 refill controller: stream/slot ids and the
// in-flight tag that pairs in-order L2 returns with their target slot.
package l1_refill_pkg;

  localparam int nstrms     = 64;
  localparam int ncl        = 16;
  localparam int sid_width  = $clog2(nstrms);
  localparam int clid_width = $clog2(ncl);

  typedef logic [sid_width-1:0]  sid_t;
  typedef logic [clid_width-1:0] clid_t;

  typedef struct packed {
    sid_t  sid;
    clid_t clid;
  } tag_t;

  // Slot pointer advance; only needs the compare when ncl is not a power of 2
  function automatic clid_t clid_next(input clid_t c);
    if (c == clid_t'(ncl - 1))
      return '0;
    else
      return clid_t'(c + 1'b1);
  endfunction

endpackage

// File: rtl/l1_refill_tagq.sv
// Tag FIFO holding {sid, clid} for every outstanding L2 read.
// Depth must be a power of 2 and at least 2.
module l1_refill_tagq
  import l1_refill_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  tag_t din,
  input  logic pop,
  output tag_t dout,
  output logic full,
  output logic empty
);

  localparam int aw = $clog2(depth);

  tag_t        mem [depth];
  logic [aw:0] wp;
  logic [aw:0] rp;

  // Extra pointer bit separates full from empty
  assign empty = (wp == rp);
  assign full  = (wp[aw] != rp[aw]) && (wp[aw-1:0] == rp[aw-1:0]);
  assign dout  = mem[rp[aw-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < depth; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp[aw-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop)
        rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/l1_refill_ctrl.sv
// Round-robin L1 cacheline refill from an in-order L2 read stream.
// Optional perf counters are enabled with L1_REFILL_PERF_EN.
module l1_refill_ctrl
  import l1_refill_pkg::*;
#(
  parameter int cl_size = 8,
  parameter int dwidth  = 64,
  parameter int maxout  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [nstrms-1:0]         i_req_v,
  output logic [nstrms-1:0]         i_req_r,
  output logic [nstrms-1:0]         o_rsp_v,
  input  logic [nstrms-1:0]         o_rsp_r,
  input  logic [nstrms-1:0]         i_srst_v,
  output logic [nstrms-1:0]         i_srst_r,
  output logic                      o_l2rd_v,
  input  logic                      o_l2rd_r,
  output logic [sid_width-1:0]      o_l2rd_sid,
  input  logic                      i_l2d_v,
  output logic                      i_l2d_r,
  input  logic [cl_size*dwidth-1:0] i_l2d_data,
  output logic                      o_wr_v,
  input  logic                      o_wr_r,
  output logic [sid_width-1:0]      o_wr_sid,
  output logic [clid_width-1:0]     o_wr_clid,
  output logic [cl_size*dwidth-1:0] o_wr_data
`ifdef L1_REFILL_PERF_EN
  ,
  output logic [31:0]               o_perf_fills,
  output logic [31:0]               o_perf_stall
`endif
);

  logic [nstrms-1:0] busy;
  logic [nstrms-1:0] rsp_pend;
  logic [nstrms-1:0] elig;
  logic [nstrms-1:0] grant;
  logic [nstrms-1:0] wr_set;
  clid_t             fill_ptr [nstrms];
  sid_t              rr_ptr;
  sid_t              gsid;
  logic              found;
  logic              load_en;
  logic              accept;
  logic              l2d_hs;
  logic              wr_hs;
  logic              q_full;
  logic              q_empty;
  tag_t              q_din;
  tag_t              q_dout;
  int                idx;

  // A pending functional reset masks the stream's grant
  assign elig    = i_req_v & ~busy & ~i_srst_v;
  assign load_en = (~o_l2rd_v | o_l2rd_r) & ~q_full & ~reset;
  assign accept  = found & load_en;
  assign i_req_r = accept ? grant : '0;

  always_comb begin
    grant = '0;
    gsid  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < nstrms; k++) begin
      idx = (int'(rr_ptr) + k) % nstrms;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        gsid       = sid_t'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign q_din = '{sid: gsid, clid: fill_ptr[gsid]};

  l1_refill_tagq #(
    .depth (maxout)
  ) u_tagq (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (q_din),
    .pop   (l2d_hs),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  assign i_l2d_r  = ~q_empty & (~o_wr_v | o_wr_r) & ~reset;
  assign l2d_hs   = i_l2d_v & i_l2d_r;
  assign wr_hs    = o_wr_v & o_wr_r;
  assign i_srst_r = reset ? '0 : ~busy;
  assign o_rsp_v  = rsp_pend;

  always_comb begin
    wr_set = '0;
    if (wr_hs)
      wr_set[o_wr_sid] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      rsp_pend   <= '0;
      rr_ptr     <= '0;
      o_l2rd_v   <= 1'b0;
      o_l2rd_sid <= '0;
      o_wr_v     <= 1'b0;
      o_wr_sid   <= '0;
      o_wr_clid  <= '0;
      o_wr_data  <= '0;
      for (int j = 0; j < nstrms; j++)
        fill_ptr[j] <= '0;
    end else begin
      for (int j = 0; j < nstrms; j++)
        if (i_srst_v[j] && i_srst_r[j])
          fill_ptr[j] <= '0;

      if (accept) begin
        fill_ptr[gsid] <= clid_next(fill_ptr[gsid]);
        rr_ptr         <= sid_t'((int'(gsid) + 1) % nstrms);
        o_l2rd_v       <= 1'b1;
        o_l2rd_sid     <= gsid;
      end else if (o_l2rd_r) begin
        o_l2rd_v <= 1'b0;
      end

      busy     <= (busy | i_req_r) & ~(rsp_pend & o_rsp_r);
      rsp_pend <= (rsp_pend & ~o_rsp_r) | wr_set;

      if (l2d_hs) begin
        o_wr_v    <= 1'b1;
        o_wr_sid  <= q_dout.sid;
        o_wr_clid <= q_dout.clid;
        o_wr_data <= i_l2d_data;
      end else if (o_wr_r) begin
        o_wr_v <= 1'b0;
      end
    end
  end

`ifdef L1_REFILL_PERF_EN
  logic stall;

  assign stall = (|elig) & ~load_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_perf_fills <= '0;
      o_perf_stall <= '0;
    end else begin
      if (wr_hs && o_perf_fills != '1)
        o_perf_fills <= o_perf_fills + 1'b1;
      if (stall && o_perf_stall != '1)
        o_perf_stall <= o_perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed bench for l1_refill_ctrl: refill flow, round-robin, tag queue
// full, slot wrap, functional reset and async reset.
module tb_l1_refill_ctrl;
  import l1_refill_pkg::*;

  localparam int LW = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic [nstrms-1:0] i_req_v;
  logic [nstrms-1:0] i_req_r;
  logic [nstrms-1:0] o_rsp_v;
  logic [nstrms-1:0] o_rsp_r;
  logic [nstrms-1:0] i_srst_v;
  logic [nstrms-1:0] i_srst_r;
  logic              o_l2rd_v;
  logic              o_l2rd_r;
  logic [sid_width-1:0] o_l2rd_sid;
  logic              i_l2d_v;
  logic              i_l2d_r;
  logic [LW-1:0]     i_l2d_data;
  logic              o_wr_v;
  logic              o_wr_r;
  logic [sid_width-1:0]  o_wr_sid;
  logic [clid_width-1:0] o_wr_clid;
  logic [LW-1:0]     o_wr_data;
`ifdef L1_REFILL_PERF_EN
  logic [31:0]       o_perf_fills;
  logic [31:0]       o_perf_stall;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int n_acc;
  logic [nstrms-1:0] one = 1;
  logic [LW-1:0] pat_a5 = {64{8'hA5}};
  logic [LW-1:0] pat_3c = {64{8'h3C}};

  l1_refill_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .i_req_v    (i_req_v),
    .i_req_r    (i_req_r),
    .o_rsp_v    (o_rsp_v),
    .o_rsp_r    (o_rsp_r),
    .i_srst_v   (i_srst_v),
    .i_srst_r   (i_srst_r),
    .o_l2rd_v   (o_l2rd_v),
    .o_l2rd_r   (o_l2rd_r),
    .o_l2rd_sid (o_l2rd_sid),
    .i_l2d_v    (i_l2d_v),
    .i_l2d_r    (i_l2d_r),
    .i_l2d_data (i_l2d_data),
    .o_wr_v     (o_wr_v),
    .o_wr_r     (o_wr_r),
    .o_wr_sid   (o_wr_sid),
    .o_wr_clid  (o_wr_clid),
    .o_wr_data  (o_wr_data)
`ifdef L1_REFILL_PERF_EN
    ,
    .o_perf_fills (o_perf_fills),
    .o_perf_stall (o_perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_v    = '0;
    i_srst_v   = '0;
    o_rsp_r    = '1;
    o_l2rd_r   = 1'b1;
    i_l2d_v    = 1'b0;
    i_l2d_data = '0;
    o_wr_r     = 1'b1;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  // Full refill of stream s with all downstream readies high
  task automatic refill(input int s, input logic [LW-1:0] d, input int ec);
    i_req_v[s] = 1'b1;
    #1;
    chk("req_r", LW'(i_req_r[s]), LW'(1));
    step();
    i_req_v[s] = 1'b0;
    #1;
    chk("l2rd_v", LW'(o_l2rd_v), LW'(1));
    chk("l2rd_sid", LW'(o_l2rd_sid), LW'(s));
    step();
    i_l2d_v    = 1'b1;
    i_l2d_data = d;
    #1;
    chk("l2d_r", LW'(i_l2d_r), LW'(1));
    step();
    i_l2d_v = 1'b0;
    #1;
    chk("wr_v", LW'(o_wr_v), LW'(1));
    chk("wr_sid", LW'(o_wr_sid), LW'(s));
    chk("wr_clid", LW'(o_wr_clid), LW'(ec));
    chk("wr_data", o_wr_data, d);
    step();
    chk("rsp_v_set", LW'(o_rsp_v[s]), LW'(1));
    step();
    chk("rsp_v_clr", LW'(o_rsp_v[s]), LW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_l2rd_v", LW'(o_l2rd_v), LW'(0));
    chk("rst_wr_v", LW'(o_wr_v), LW'(0));
    chk("rst_rsp_v", LW'(o_rsp_v), LW'(0));
    chk("rst_l2d_r", LW'(i_l2d_r), LW'(0));
    chk("rst_req_r", LW'(i_req_r), LW'(0));

    // Single refill, then second refill lands in the next slot
    refill(5, pat_a5, 0);
    refill(5, pat_3c, 1);

    // Round-robin 3, 7, 60 from a fresh pointer
    reset_pulse();
    i_req_v = (one << 3) | (one << 7) | (one << 60);
    #1;
    chk("rr_g0", LW'(i_req_r), LW'(one << 3));
    step();
    chk("rr_sid0", LW'(o_l2rd_sid), LW'(3));
    chk("rr_g1", LW'(i_req_r), LW'(one << 7));
    step();
    chk("rr_sid1", LW'(o_l2rd_sid), LW'(7));
    chk("rr_g2", LW'(i_req_r), LW'(one << 60));
    step();
    chk("rr_sid2", LW'(o_l2rd_sid), LW'(60));
    i_req_v = one << 3;
    i_l2d_v = 1'b1;
    #1;
    chk("rr_busy3", LW'(i_req_r), LW'(0));
    step();
    chk("rr_wr0", LW'(o_wr_sid), LW'(3));
    step();
    chk("rr_wr1", LW'(o_wr_sid), LW'(7));
    chk("rr_rsp3", LW'(o_rsp_v[3]), LW'(1));
    step();
    i_l2d_v = 1'b0;
    #1;
    chk("rr_wr2", LW'(o_wr_sid), LW'(60));
    chk("rr_regrant3", LW'(i_req_r), LW'(one << 3));

    // Tag queue full with data withheld
    reset_pulse();
    i_req_v = nstrms'(64'h3F);
    n_acc   = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (|i_req_r)
        n_acc++;
      step();
    end
    chk("q_accepts", LW'(n_acc), LW'(4));
    chk("q_full_req_r", LW'(i_req_r), LW'(0));
    i_l2d_v = 1'b1;
    #1;
    chk("q_l2d_r", LW'(i_l2d_r), LW'(1));
    step();
    i_l2d_v = 1'b0;
    #1;
    chk("q_one_more", LW'(i_req_r), LW'(one << 4));
    step();
    chk("q_full_again", LW'(i_req_r), LW'(0));

    // Slot pointer wrap on stream 0
    reset_pulse();
    for (int k = 0; k < 17; k++)
      refill(0, pat_a5 ^ LW'(k), k % 16);

    // Functional reset held off while stream 2 is busy
    reset_pulse();
    o_rsp_r[2] = 1'b0;
    i_req_v[2] = 1'b1;
    step();
    i_req_v[2]  = 1'b0;
    i_srst_v[2] = 1'b1;
    #1;
    chk("srst_busy0", LW'(i_srst_r[2]), LW'(0));
    step();
    i_l2d_v = 1'b1;
    step();
    i_l2d_v = 1'b0;
    step();
    chk("srst_rsp_v", LW'(o_rsp_v[2]), LW'(1));
    chk("srst_busy1", LW'(i_srst_r[2]), LW'(0));
    step();
    chk("srst_busy2", LW'(i_srst_r[2]), LW'(0));
    o_rsp_r[2] = 1'b1;
    step();
    chk("srst_free", LW'(i_srst_r[2]), LW'(1));
    step();
    i_srst_v[2] = 1'b0;
    refill(2, pat_3c, 0);
    i_req_v[9]  = 1'b1;
    i_srst_v[9] = 1'b1;
    #1;
    chk("srst9_nogrant", LW'(i_req_r[9]), LW'(0));
    chk("srst9_ready", LW'(i_srst_r[9]), LW'(1));
    step();
    i_req_v[9]  = 1'b0;
    i_srst_v[9] = 1'b0;
    #1;
    chk("srst9_no_l2rd", LW'(o_l2rd_v), LW'(0));

    // Async reset with three reads in flight
    refill(1, pat_a5, 0);
    o_wr_r  = 1'b0;
    i_req_v = (one << 4) | (one << 5) | (one << 6);
    step();
    i_l2d_v = 1'b1;
    step();
    i_l2d_v = 1'b0;
    step();
    chk("pre_l2rd_v", LW'(o_l2rd_v), LW'(1));
    chk("pre_wr_v", LW'(o_wr_v), LW'(1));
    reset = 1'b1;
    #1;
    chk("ar_l2rd_v", LW'(o_l2rd_v), LW'(0));
    chk("ar_wr_v", LW'(o_wr_v), LW'(0));
    chk("ar_rsp_v", LW'(o_rsp_v), LW'(0));
    chk("ar_req_r", LW'(i_req_r), LW'(0));
    chk("ar_srst_r", LW'(i_srst_r), LW'(0));
    chk("ar_l2d_r", LW'(i_l2d_r), LW'(0));
    idle_inputs();
    reset = 1'b0;
    #1;
    refill(1, pat_3c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_refill_ctrl.md
Name: l1_refill_ctrl

Overview:
- Sits directly downstream of the L1 control top's per-stream cacheline request outputs (o_req_v/o_req_r), and supplies its per-stream response inputs (i_rsp_v/i_rsp_r).
- Round-robin arbitrates nstrms refill requests into one L2 URAM read stream. Pairs the in-order L2 data returns with queued tags, then writes whole cachelines into the L1 BRAM slot.
- Tracks each stream's next-fill cacheline slot and acknowledges the stream once its line is written.

Parameters:
- nstrms, 64, total number of streams
- ncl, 16, cachelines per stream in L1
- cl_size, 8, reads (words) per cacheline
- dwidth, 64, bits per word
- maxout, 4, maximum outstanding L2 reads (tag queue depth; power of 2)
- sid_width, $clog2(nstrms), stream id width
- clid_width, $clog2(ncl), cacheline slot id width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_req_v  in  nstrms  per-stream cacheline refill request valid
- i_req_r  out  nstrms  per-stream request ready
- o_rsp_v  out  nstrms  per-stream "line written" response valid
- o_rsp_r  in  nstrms  per-stream response ready
- i_srst_v  in  nstrms  per-stream functional reset valid
- i_srst_r  out  nstrms  per-stream functional reset ready
- o_l2rd_v  out  1  L2 read request valid
- o_l2rd_r  in  1  L2 read request ready
- o_l2rd_sid  out  sid_width  stream to read from L2
- i_l2d_v  in  1  L2 cacheline data valid (in issue order)
- i_l2d_r  out  1  L2 data ready
- i_l2d_data  in  cl_size*dwidth  cacheline data
- o_wr_v  out  1  L1 BRAM write valid
- o_wr_r  in  1  L1 BRAM write ready
- o_wr_sid  out  sid_width  target stream
- o_wr_clid  out  clid_width  target cacheline slot
- o_wr_data  out  cl_size*dwidth  cacheline data

Behaviour:
- Reset (async, active-high): all valids 0; i_req_r=0; i_srst_r=0; i_l2d_r=0. fill_ptr[*]=0, busy[*]=0, rsp_pend[*]=0, RR pointer=0, tag queue empty, o_* data registers 0.
- busy[j]: set on request accept, cleared on response handshake. Each stream has at most one refill in flight.
- Eligibility: stream j is eligible when i_req_v[j] & ~busy[j] & ~i_srst_v[j].
- Issue stage:
  - load_en = (~o_l2rd_v | o_l2rd_r) & tagq not full.
  - The RR arbiter grants the first eligible stream at or after rr_ptr, wrapping mod nstrms.
  - i_req_r[j] = grant[j] & load_en; only one bit is high per cycle.
  - On accept of stream j:
    - o_l2rd_v=1 and o_l2rd_sid=j next cycle.
    - Push {j, fill_ptr[j]} to tagq.
    - fill_ptr[j] increments, wrapping ncl-1 -> 0.
    - busy[j]=1; rr_ptr=j+1 mod nstrms.
- Latency, request handshake to o_l2rd_v: 1 cycle. Full throughput is one request per cycle when o_l2rd_r=1.
- Tagq full (maxout entries): no grants, i_req_r=0.
- Data stage:
  - i_l2d_r = tagq not empty & (~o_wr_v | o_wr_r).
  - On data handshake: pop tagq into {o_wr_sid, o_wr_clid}, o_wr_data=i_l2d_data, o_wr_v=1 next cycle.
  - i_l2d_v with tagq empty is a protocol error: stalled, never accepted.
  - A push and a pop in the same cycle are both legal. A push at full is impossible, because load_en already blocks it.
- Response stage:
  - On o_wr handshake for sid s: rsp_pend[s]=1 next cycle; o_rsp_v=rsp_pend.
  - On o_rsp_v[s]&o_rsp_r[s]: rsp_pend[s]=0 and busy[s]=0. Stream s is eligible again the following cycle.
- Functional reset:
  - i_srst_r[j] = ~busy[j]. On handshake, fill_ptr[j]=0.
  - While busy, the reset is held off until the response completes.
  - i_srst_v[j] masks a grant to j in the same cycle; reset has priority.
- Data width rules: fill_ptr wraps naturally when ncl is a power of 2; otherwise it is an explicit compare to ncl-1.

Optional Feature:
- Macro: L1_REFILL_PERF_EN.
- With it defined, two output ports are added:
  - o_perf_fills[31:0]: increments on each o_wr handshake.
  - o_perf_stall[31:0]: increments each cycle with any eligible request but load_en=0.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Without it: the ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Package l1_refill_pkg holds:
  - typedef tag_t {sid, clid};
  - localparams sid_width and clid_width derived from nstrms and ncl.
- Sub-module l1_refill_tagq: synchronous FIFO, depth maxout, width of tag_t. Provides push/pop and full/empty flags, plus async reset.

Test Plan:
- Single refill: req stream 5 -> o_l2rd_sid=5 one cycle after accept. Data 0xA5.. -> o_wr_sid=5, o_wr_clid=0. o_rsp_v[5] one cycle after write handshake. Second refill of stream 5 -> clid=1.
- Round-robin fairness: streams 3, 7, 60 all requesting, o_l2rd_r=1 -> issue order 3, 7, 60; then 3 is blocked (busy) until its response.
- Tagq full: maxout=4, L2 data withheld, 6 streams requesting -> exactly 4 accepts, then i_req_r=0. One data return -> one more accept.
- Wrap: 16 consecutive refills of stream 0 -> clid 0..15, then the 17th gets clid 0.
- Functional reset: stream 2 busy, i_srst_v[2]=1 -> i_srst_r[2]=0 until the response handshake, then fill_ptr[2]=0. Simultaneous req and srst on stream 9 -> srst accepted, no grant that cycle.
- Async reset mid-operation: assert reset with 3 in flight -> all valids 0 immediately, fill_ptr=0. A post-reset refill of stream 1 -> clid 0.
